// File: rtl/seg_scan_if.sv
// Bus between the segment pattern generator and the seven-segment scanner:
// eight active-low patterns in, shared segment bus and digit enables out.
interface seg_scan_if;
  logic       en;
  logic [7:0] seg0;
  logic [7:0] seg1;
  logic [7:0] seg2;
  logic [7:0] seg3;
  logic [7:0] seg4;
  logic [7:0] seg5;
  logic [7:0] seg6;
  logic [7:0] seg7;
  logic [7:0] seg_out;
  logic [7:0] an;
  logic [2:0] digit_idx;
  logic       frame_done;
  // Debug view of the scanner FSM: 1 while a scan frame is in progress.
  logic       scanning;

  modport master (
    output en, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7,
    input  seg_out, an, digit_idx, frame_done, scanning
  );

  modport slave (
    input  en, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7,
    output seg_out, an, digit_idx, frame_done, scanning
  );
endinterface

// File: rtl/seg_scan.sv
// Time-multiplexed seven-segment scanner: one digit per CLK_DIV-cycle slot,
// BLANK_CYCLES of all-off at each slot start, patterns captured once per frame.
module seg_scan #(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input logic      clk,
  input logic      rst,
  seg_scan_if.slave bus
);
  localparam int SW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(CLK_DIV - 1);

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] slot, slot_nxt;
  logic [2:0]    dig, dig_nxt;
  logic [7:0]    shadow [8];
  logic [7:0]    shadow_nxt [8];
  logic [7:0]    seg_in [8];
  logic [7:0]    seg_out_q, seg_out_nxt;
  logic [7:0]    an_q, an_nxt;
  logic          fd_q, fd_nxt;
  logic          blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      slot      <= '0;
      dig       <= '0;
      shadow    <= '{default: 8'hFF};
      seg_out_q <= 8'hFF;
      an_q      <= 8'hFF;
      fd_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      slot      <= slot_nxt;
      dig       <= dig_nxt;
      shadow    <= shadow_nxt;
      seg_out_q <= seg_out_nxt;
      an_q      <= an_nxt;
      fd_q      <= fd_nxt;
    end
  end

  // Outputs are computed from the next slot/digit so they line up with the
  // edge that advances the counters; a wrap edge displays the fresh capture.
  always_comb begin
    seg_in      = '{bus.seg0, bus.seg1, bus.seg2, bus.seg3,
                    bus.seg4, bus.seg5, bus.seg6, bus.seg7};
    state_nxt   = ST_IDLE;
    slot_nxt    = '0;
    dig_nxt     = '0;
    shadow_nxt  = shadow;
    seg_out_nxt = 8'hFF;
    an_nxt      = 8'hFF;
    fd_nxt      = 1'b0;
    blank       = 1'b1;
    if (bus.en) begin
      state_nxt = ST_SCAN;
      if (state == ST_SCAN) begin
        if (slot == SLOT_LAST) begin
          slot_nxt = '0;
          dig_nxt  = dig + 3'd1;
        end else begin
          slot_nxt = slot + SW'(1);
          dig_nxt  = dig;
        end
      end
      if (slot_nxt == '0 && dig_nxt == 3'd0) shadow_nxt = seg_in;
      blank = int'(slot_nxt) < BLANK_CYCLES;
      if (!blank) begin
        an_nxt      = ~(8'b1 << dig_nxt);
        seg_out_nxt = shadow_nxt[dig_nxt];
      end
      fd_nxt = (slot_nxt == SLOT_LAST) && (dig_nxt == 3'd7);
    end
  end

  assign bus.seg_out    = seg_out_q;
  assign bus.an         = an_q;
  assign bus.digit_idx  = dig;
  assign bus.frame_done = fd_q;
  assign bus.scanning   = (state == ST_SCAN);
endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: two instances (4/1 and 2/0 timing) run against a
// behavioural model; expected outputs are queued per edge and compared after it.
module tb_seg_scan;
  logic clk;
  logic rst_a, rst_b;
  logic en_a, en_b;
  logic [7:0] seg_a [8];
  logic [7:0] seg_b [8];

  seg_scan_if ifa ();
  seg_scan_if ifb ();

  assign ifa.en = en_a;
  assign ifa.seg0 = seg_a[0];
  assign ifa.seg1 = seg_a[1];
  assign ifa.seg2 = seg_a[2];
  assign ifa.seg3 = seg_a[3];
  assign ifa.seg4 = seg_a[4];
  assign ifa.seg5 = seg_a[5];
  assign ifa.seg6 = seg_a[6];
  assign ifa.seg7 = seg_a[7];
  assign ifb.en = en_b;
  assign ifb.seg0 = seg_b[0];
  assign ifb.seg1 = seg_b[1];
  assign ifb.seg2 = seg_b[2];
  assign ifb.seg3 = seg_b[3];
  assign ifb.seg4 = seg_b[4];
  assign ifb.seg5 = seg_b[5];
  assign ifb.seg6 = seg_b[6];
  assign ifb.seg7 = seg_b[7];

  seg_scan #(.CLK_DIV(4), .BLANK_CYCLES(1)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
  seg_scan #(.CLK_DIV(2), .BLANK_CYCLES(0)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // scoreboard: {seg_out, an, digit_idx, frame_done}
  logic [19:0] exp_qa[$];
  logic [19:0] exp_qb[$];
  int          mn [2];
  logic [7:0]  msh [2][8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input int k, input int cd, input int bl, input logic r,
                       input logic e, input logic [7:0] sg [8], output logic [19:0] ex);
    int s, d;
    logic [7:0] a, so;
    if (r) begin
      mn[k] = -1;
      for (int i = 0; i < 8; i++) msh[k][i] = 8'hFF;
      ex = {8'hFF, 8'hFF, 3'd0, 1'b0};
    end else if (!e) begin
      mn[k] = -1;
      ex = {8'hFF, 8'hFF, 3'd0, 1'b0};
    end else begin
      mn[k] = (mn[k] < 0) ? 0 : mn[k] + 1;
      if (mn[k] % (8 * cd) == 0)
        for (int i = 0; i < 8; i++) msh[k][i] = sg[i];
      s = mn[k] % cd;
      d = (mn[k] / cd) % 8;
      a = 8'b1 << d;
      a = ~a;
      so = msh[k][d];
      if (s < bl) begin
        a  = 8'hFF;
        so = 8'hFF;
      end
      ex = {so, a, 3'(d), (mn[k] % (8 * cd)) == (8 * cd - 1)};
    end
  endtask

  // driver: push expectations for the coming edge, then compare after it
  task automatic step();
    logic [19:0] ea, eb, pa, pb;
    model(0, 4, 1, rst_a, en_a, seg_a, ea);
    model(1, 2, 0, rst_b, en_b, seg_b, eb);
    exp_qa.push_back(ea);
    exp_qb.push_back(eb);
    @(posedge clk);
    #1;
    pa = exp_qa.pop_front();
    pb = exp_qb.pop_front();
    check("a_out", {12'd0, ifa.seg_out, ifa.an, ifa.digit_idx, ifa.frame_done}, {12'd0, pa});
    check("b_out", {12'd0, ifb.seg_out, ifb.an, ifb.digit_idx, ifb.frame_done}, {12'd0, pb});
    if (ifa.an != 8'hFF && $countones(~ifa.an) != 1) check("a_onehot", ifa.an, 8'hFE);
    if (ifb.an != 8'hFF && $countones(~ifb.an) != 1) check("b_onehot", ifb.an, 8'hFE);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    mn = '{-1, -1};
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      seg_a[i] = 8'($urandom_range(0, 255));
      seg_b[i] = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    // reset held with en=1
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_an", ifa.an, 8'hFF);
      check("rst_seg", ifa.seg_out, 8'hFF);
      check("rst_scan", {31'd0, ifa.scanning}, 32'd0);
    end

    // basic scan
    for (int i = 0; i < 8; i++) seg_a[i] = 8'hFF;
    seg_a[0] = 8'h03; seg_a[1] = 8'h9F;
    rst_a = 1'b0; rst_b = 1'b0;
    step();                                   // edge 0
    check("e0_an", ifa.an, 8'hFF);
    step();                                   // edge 1
    check("e1_an", ifa.an, 8'hFE);
    check("e1_seg", ifa.seg_out, 8'h03);
    check("b_e1_an", ifb.an, 8'hFE);
    steps(3);                                 // edges 2..4
    check("e4_an", ifa.an, 8'hFF);
    step();                                   // edge 5
    check("e5_an", ifa.an, 8'hFD);
    check("e5_seg", ifa.seg_out, 8'h9F);
    steps(4);                                 // edges 6..9
    check("e9_an", ifa.an, 8'hFB);
    seg_a[0] = 8'h9F;                         // sampled at edge 10, mid-frame
    steps(5);                                 // edges 10..14
    check("b_e14_fd", {31'd0, ifb.frame_done}, 32'd0);
    step();                                   // edge 15
    check("b_e15_fd", {31'd0, ifb.frame_done}, 32'd1);
    steps(15);                                // edges 16..30
    check("e30_fd", {31'd0, ifa.frame_done}, 32'd0);
    step();                                   // edge 31
    check("e31_fd", {31'd0, ifa.frame_done}, 32'd1);
    step();                                   // edge 32
    check("e32_an", ifa.an, 8'hFF);
    step();                                   // edge 33
    check("e33_an", ifa.an, 8'hFE);
    check("e33_seg", ifa.seg_out, 8'h9F);
    steps(2);

    // enable abort mid-slot, then restart with a fresh capture
    steps(5);
    en_a = 1'b0;
    step();
    check("abort_an", ifa.an, 8'hFF);
    check("abort_dig", {29'd0, ifa.digit_idx}, 32'd0);
    en_a = 1'b1;
    seg_a[0] = 8'h25;
    step();
    check("re_e0_an", ifa.an, 8'hFF);
    step();
    check("re_e1_an", ifa.an, 8'hFE);
    check("re_e1_seg", ifa.seg_out, 8'h25);

    // mid-frame reset at edge 22 of this frame (digit 5)
    steps(20);
    check("pre_rst_dig", {29'd0, ifa.digit_idx}, 32'd5);
    rst_a = 1'b1;
    step();
    check("mrst_an", ifa.an, 8'hFF);
    check("mrst_dig", {29'd0, ifa.digit_idx}, 32'd0);
    rst_a = 1'b0;
    seg_a[0] = 8'h11;
    steps(2);
    check("mrst_seg", ifa.seg_out, 8'h11);
    steps(40);

    // random traffic on both instances
    for (int c = 0; c < 300; c++) begin
      en_a  = ($urandom_range(0, 31) != 0);
      en_b  = ($urandom_range(0, 31) != 0);
      rst_a = ($urandom_range(0, 99) == 0);
      rst_b = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) seg_a[$urandom_range(0, 7)] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) seg_b[$urandom_range(0, 7)] = 8'($urandom_range(0, 255));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
